decode_stage: RTL and testbench

Registered, parametrised instruction-decode stage for the processor pipeline. It sits between instruction fetch and execute. Each cycle it splits one microcode word into an opcode and an additional field and translates the opcode into the datapath control bundle. The bundle is held in an ID/EX pipeline register behind a valid/ready handshake. A per-register writeback scoreboard stalls fetch on read-after-write hazards against registers A and B, and a flush input kills the held instruction on a taken branch.

---
 rtl/decode_stage_pkg.sv | 38 +++
 rtl/decode_stage_decode_table.sv | 40 ++++
 rtl/decode_stage.sv | 115 +++++++++++
 tb/tb_decode_stage.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_stage_pkg.sv
// Shared definitions for the decode stage: opcode and ALU encodings, and the
// datapath control bundle with its reset value.
package decode_stage_pkg;

    localparam int unsigned OP_NOP = 0;
    localparam int unsigned OP_LDA = 1;
    localparam int unsigned OP_LDB = 2;
    localparam int unsigned OP_STA = 3;
    localparam int unsigned OP_STB = 4;
    localparam int unsigned OP_ADD = 5;
    localparam int unsigned OP_SUB = 6;
    localparam int unsigned OP_AND = 7;
    localparam int unsigned OP_OR  = 8;
    localparam int unsigned OP_BRA = 9;
    localparam int unsigned OP_BZ  = 10;

    localparam int unsigned ALU_ADD = 0;
    localparam int unsigned ALU_SUB = 1;
    localparam int unsigned ALU_AND = 2;
    localparam int unsigned ALU_OR  = 3;
    localparam int unsigned ALU_NOP = 7;

    typedef struct packed {
        logic en_a_id;
        logic en_b_id;
        logic en_a_wb;
        logic en_b_wb;
        logic branch;
        logic sel_mux_a;
        logic sel_mux_b;
        logic en_mem;
        logic sel_mem_data;
    } ctrl_t;

    localparam int unsigned CTRL_W = $bits(ctrl_t);
    localparam ctrl_t CTRL_RESET = '0;

endpackage

// File: rtl/decode_stage_decode_table.sv
// Combinational opcode decoder: control bundle, ALU code and the register
// read/write masks used by the hazard scoreboard.
module decode_table
    import decode_stage_pkg::*;
#(
    parameter int unsigned OPCODE_W = 6,
    parameter int unsigned ALU_W    = 4
) (
    input  logic [OPCODE_W-1:0] opcode,
    output logic [CTRL_W-1:0]   ctrl,
    output logic [ALU_W-1:0]    alu_ctrl,
    output logic [1:0]          rd_mask,
    output logic [1:0]          wr_mask
);

    ctrl_t c;

    always_comb begin
        c        = CTRL_RESET;
        alu_ctrl = ALU_W'(ALU_NOP);
        case (opcode)
            OPCODE_W'(OP_LDA): begin c.en_a_wb = 1'b1; c.en_mem = 1'b1; c.sel_mem_data = 1'b1; end
            OPCODE_W'(OP_LDB): begin c.en_b_wb = 1'b1; c.en_mem = 1'b1; c.sel_mem_data = 1'b1; end
            OPCODE_W'(OP_STA): begin c.en_a_id = 1'b1; c.en_mem = 1'b1; end
            OPCODE_W'(OP_STB): begin c.en_b_id = 1'b1; c.en_mem = 1'b1; end
            OPCODE_W'(OP_ADD): begin c.en_a_id = 1'b1; c.en_b_id = 1'b1; c.en_a_wb = 1'b1; alu_ctrl = ALU_W'(ALU_ADD); end
            OPCODE_W'(OP_SUB): begin c.en_a_id = 1'b1; c.en_b_id = 1'b1; c.en_a_wb = 1'b1; alu_ctrl = ALU_W'(ALU_SUB); end
            OPCODE_W'(OP_AND): begin c.en_a_id = 1'b1; c.en_b_id = 1'b1; c.en_a_wb = 1'b1; alu_ctrl = ALU_W'(ALU_AND); end
            OPCODE_W'(OP_OR):  begin c.en_a_id = 1'b1; c.en_b_id = 1'b1; c.en_a_wb = 1'b1; alu_ctrl = ALU_W'(ALU_OR); end
            OPCODE_W'(OP_BRA): begin c.branch = 1'b1; end
            OPCODE_W'(OP_BZ):  begin c.branch = 1'b1; c.en_a_id = 1'b1; end
            default: ;
        endcase
    end

    assign ctrl    = c;
    assign rd_mask = {c.en_b_id, c.en_a_id};
    assign wr_mask = {c.en_b_wb, c.en_a_wb};

endmodule

// File: rtl/decode_stage.sv
// ID/EX decode stage: decodes one word per cycle into a registered control
// bundle behind a valid/ready handshake, with RAW scoreboard and flush.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int unsigned INSTR_W    = 16,
    parameter int unsigned OPCODE_W   = 6,
    parameter int unsigned ALU_W      = 4,
    parameter int unsigned WB_LATENCY = 3
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [INSTR_W-1:0]    iInstruction,
    input  logic                  iValid,
    output logic                  oReady,
    input  logic                  iReady,
    input  logic                  iFlush,
    output logic                  oValid,
    output logic [INSTR_W-OPCODE_W-1:0] oAditional,
    output logic                  oEnableA_ID,
    output logic                  oEnableB_ID,
    output logic                  oEnableA_WB,
    output logic                  oEnableB_WB,
    output logic [ALU_W-1:0]      oALUControl,
    output logic                  oBranchOperation,
    output logic                  oSelectMuxRegA,
    output logic                  oSelectMuxesRegB,
    output logic                  oEnableMem,
    output logic                  oSelectInputMemData
);

    localparam int unsigned ADD_W = INSTR_W - OPCODE_W;
    localparam logic [3:0] CNT_LOAD = 4'(WB_LATENCY);

    logic [CTRL_W-1:0] dec_ctrl;
    logic [ALU_W-1:0]  dec_alu;
    logic [1:0]        rd_mask, wr_mask;

    decode_table #(.OPCODE_W(OPCODE_W), .ALU_W(ALU_W)) u_table (
        .opcode   (iInstruction[INSTR_W-1 -: OPCODE_W]),
        .ctrl     (dec_ctrl),
        .alu_ctrl (dec_alu),
        .rd_mask  (rd_mask),
        .wr_mask  (wr_mask)
    );

    logic              valid_q, valid_d;
    ctrl_t             ctrl_q, ctrl_d;
    logic [ALU_W-1:0]  alu_q, alu_d;
    logic [ADD_W-1:0]  add_q, add_d;
    logic [3:0]        cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
    logic [3:0]        cnt_a_dec, cnt_b_dec;
    logic              hazard, advance, issue;

    always_comb begin
        cnt_a_dec = (iReady && cnt_a_q != '0) ? cnt_a_q - 4'd1 : cnt_a_q;
        cnt_b_dec = (iReady && cnt_b_q != '0) ? cnt_b_q - 4'd1 : cnt_b_q;
        // A reader may issue on the very edge where the writer's counter expires.
        hazard  = iValid && ((rd_mask[0] && cnt_a_dec != '0) || (rd_mask[1] && cnt_b_dec != '0));
        advance = !valid_q || iReady;
        oReady  = advance && !hazard && !iFlush;
        issue   = oReady && iValid;

        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        alu_d   = alu_q;
        add_d   = add_q;
        if (iFlush || (advance && !issue)) begin
            valid_d = 1'b0;
            ctrl_d  = CTRL_RESET;
            alu_d   = ALU_W'(ALU_NOP);
            add_d   = '0;
        end else if (issue) begin
            valid_d = 1'b1;
            ctrl_d  = ctrl_t'(dec_ctrl);
            alu_d   = dec_alu;
            add_d   = iInstruction[ADD_W-1:0];
        end

        cnt_a_d = (issue && wr_mask[0]) ? CNT_LOAD : cnt_a_dec;
        cnt_b_d = (issue && wr_mask[1]) ? CNT_LOAD : cnt_b_dec;
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            valid_q <= 1'b0;
            ctrl_q  <= CTRL_RESET;
            alu_q   <= ALU_W'(ALU_NOP);
            add_q   <= '0;
            cnt_a_q <= '0;
            cnt_b_q <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            alu_q   <= alu_d;
            add_q   <= add_d;
            cnt_a_q <= cnt_a_d;
            cnt_b_q <= cnt_b_d;
        end
    end

    assign oValid              = valid_q;
    assign oAditional          = add_q;
    assign oEnableA_ID         = ctrl_q.en_a_id;
    assign oEnableB_ID         = ctrl_q.en_b_id;
    assign oEnableA_WB         = ctrl_q.en_a_wb;
    assign oEnableB_WB         = ctrl_q.en_b_wb;
    assign oALUControl         = alu_q;
    assign oBranchOperation    = ctrl_q.branch;
    assign oSelectMuxRegA      = ctrl_q.sel_mux_a;
    assign oSelectMuxesRegB    = ctrl_q.sel_mux_b;
    assign oEnableMem          = ctrl_q.en_mem;
    assign oSelectInputMemData = ctrl_q.sel_mem_data;

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage: reset, streaming, RAW stall,
// backpressure, flush and asynchronous reset mid-stall.
module tb_decode_stage;
    import decode_stage_pkg::*;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic [15:0] iInstruction = '0;
    logic        iValid = 1'b0;
    logic        iReady = 1'b1;
    logic        iFlush = 1'b0;
    logic        oReady, oValid;
    logic [9:0]  oAditional;
    logic        oEnableA_ID, oEnableB_ID, oEnableA_WB, oEnableB_WB;
    logic [3:0]  oALUControl;
    logic        oBranchOperation, oSelectMuxRegA, oSelectMuxesRegB, oEnableMem, oSelectInputMemData;

    int errors = 0;
    int checks = 0;

    // Flag order: V, A_ID, B_ID, A_WB, B_WB, BR, MUXA, MUXB, MEM, MEMDATA
    localparam logic [9:0] F_LDA = 10'b1001000011;
    localparam logic [9:0] F_LDB = 10'b1000100011;
    localparam logic [9:0] F_STA = 10'b1100000010;
    localparam logic [9:0] F_STB = 10'b1010000010;
    localparam logic [9:0] F_ALU = 10'b1111000000;
    localparam logic [9:0] F_NOP = 10'b1000000000;
    localparam logic [9:0] F_BRA = 10'b1000010000;
    localparam logic [9:0] F_BZ  = 10'b1100010000;
    localparam logic [23:0] RST_OBS = {10'b0, 4'd7, 10'h000};

    decode_stage #(.INSTR_W(16), .OPCODE_W(6), .ALU_W(4), .WB_LATENCY(3)) dut (
        .Clock(Clock), .Reset(Reset), .iInstruction(iInstruction), .iValid(iValid),
        .oReady(oReady), .iReady(iReady), .iFlush(iFlush), .oValid(oValid),
        .oAditional(oAditional), .oEnableA_ID(oEnableA_ID), .oEnableB_ID(oEnableB_ID),
        .oEnableA_WB(oEnableA_WB), .oEnableB_WB(oEnableB_WB), .oALUControl(oALUControl),
        .oBranchOperation(oBranchOperation), .oSelectMuxRegA(oSelectMuxRegA),
        .oSelectMuxesRegB(oSelectMuxesRegB), .oEnableMem(oEnableMem),
        .oSelectInputMemData(oSelectInputMemData)
    );

    always #5 Clock = ~Clock;

    function automatic logic [15:0] mk(input int unsigned op, input logic [9:0] a);
        logic [5:0] o;
        o = 6'(op);
        return {o, a};
    endfunction

    function automatic logic [23:0] obs();
        return {oValid, oEnableA_ID, oEnableB_ID, oEnableA_WB, oEnableB_WB, oBranchOperation,
                oSelectMuxRegA, oSelectMuxesRegB, oEnableMem, oSelectInputMemData,
                oALUControl, oAditional};
    endfunction

    task automatic drive(input logic v, input logic [15:0] ins, input logic rdy, input logic fl);
        iValid = v; iInstruction = ins; iReady = rdy; iFlush = fl;
        #1;
    endtask

    task automatic cycle();
        @(posedge Clock);
        #1;
    endtask

    task automatic drain();
        drive(1'b0, '0, 1'b1, 1'b0);
        repeat (4) cycle();
    endtask

    task automatic test_reset();
        #1 Reset = 1'b0;
        drive(1'b1, mk(OP_LDA, 10'h155), 1'b1, 1'b0);
        repeat (2) cycle();
        checks++;
        if (obs() !== RST_OBS) begin
            errors++; $display("FAIL reset_state: got %h want %h", obs(), RST_OBS);
        end
        #2 Reset = 1'b1;
        cycle();
        checks++;
        if (obs() !== {F_LDA, 4'd7, 10'h155}) begin
            errors++; $display("FAIL first_lda: got %h want %h", obs(), {F_LDA, 4'd7, 10'h155});
        end
        drain();
    endtask

    task automatic test_streaming();
        logic [15:0] ins [4];
        logic [23:0] exp [4];
        ins = '{mk(OP_LDA, 10'h001), mk(OP_LDB, 10'h002), mk(OP_NOP, 10'h003), 16'hFC04};
        exp = '{{F_LDA, 4'd7, 10'h001}, {F_LDB, 4'd7, 10'h002},
                {F_NOP, 4'd7, 10'h003}, {F_NOP, 4'd7, 10'h004}};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, ins[i], 1'b1, 1'b0);
            checks++;
            if (oReady !== 1'b1) begin
                errors++; $display("FAIL stream_ready[%0d]: got %b want 1", i, oReady);
            end
            cycle();
            checks++;
            if (obs() !== exp[i]) begin
                errors++; $display("FAIL stream_bundle[%0d]: got %h want %h", i, obs(), exp[i]);
            end
        end
        drain();
    endtask

    task automatic test_raw_stall();
        int stalls, bubbles;
        drive(1'b1, mk(OP_LDA, 10'h0A0), 1'b1, 1'b0);
        cycle();
        drive(1'b1, mk(OP_STA, 10'h0A1), 1'b1, 1'b0);
        stalls = 0; bubbles = 0;
        for (int n = 0; n < 10 && oReady !== 1'b1; n++) begin
            stalls++;
            cycle();
            if (oValid === 1'b0) bubbles++;
        end
        checks++;
        if (stalls != 2 || bubbles != 2) begin
            errors++; $display("FAIL raw_stall_count: got stalls=%0d bubbles=%0d want 2/2", stalls, bubbles);
        end
        cycle();
        checks++;
        if (obs() !== {F_STA, 4'd7, 10'h0A1}) begin
            errors++; $display("FAIL raw_sta_bundle: got %h want %h", obs(), {F_STA, 4'd7, 10'h0A1});
        end
        drain();
        drive(1'b1, mk(OP_LDB, 10'h0B0), 1'b1, 1'b0);
        cycle();
        drive(1'b1, mk(OP_STA, 10'h0B1), 1'b1, 1'b0);
        checks++;
        if (oReady !== 1'b1) begin
            errors++; $display("FAIL no_stall_ready: got %b want 1", oReady);
        end
        cycle();
        checks++;
        if (obs() !== {F_STA, 4'd7, 10'h0B1}) begin
            errors++; $display("FAIL no_stall_bundle: got %h want %h", obs(), {F_STA, 4'd7, 10'h0B1});
        end
        drain();
    endtask

    task automatic test_backpressure();
        int stalls;
        drive(1'b1, mk(OP_ADD, 10'h0C0), 1'b1, 1'b0);
        cycle();
        checks++;
        if (obs() !== {F_ALU, 4'd0, 10'h0C0}) begin
            errors++; $display("FAIL add_bundle: got %h want %h", obs(), {F_ALU, 4'd0, 10'h0C0});
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, (i % 2 == 1) ? mk(OP_LDB, 10'h3FF) : mk(OP_STA, 10'h0C1), 1'b0, 1'b0);
            checks++;
            if (oReady !== 1'b0) begin
                errors++; $display("FAIL hold_ready[%0d]: got %b want 0", i, oReady);
            end
            cycle();
            checks++;
            if (obs() !== {F_ALU, 4'd0, 10'h0C0}) begin
                errors++; $display("FAIL hold_stable[%0d]: got %h want %h", i, obs(), {F_ALU, 4'd0, 10'h0C0});
            end
        end
        drive(1'b1, mk(OP_STA, 10'h0C1), 1'b1, 1'b0);
        stalls = 0;
        for (int n = 0; n < 10 && oReady !== 1'b1; n++) begin
            stalls++;
            cycle();
        end
        checks++;
        if (stalls != 2) begin
            errors++; $display("FAIL bp_remaining_stall: got %0d want 2", stalls);
        end
        cycle();
        checks++;
        if (obs() !== {F_STA, 4'd7, 10'h0C1}) begin
            errors++; $display("FAIL bp_sta_bundle: got %h want %h", obs(), {F_STA, 4'd7, 10'h0C1});
        end
        drain();
    endtask

    task automatic test_classes();
        logic [15:0] ins [5];
        logic [23:0] exp [5];
        ins = '{mk(OP_SUB, 10'h011), mk(OP_AND, 10'h022), mk(OP_OR, 10'h033),
                mk(OP_BRA, 10'h044), mk(OP_BZ, 10'h055)};
        exp = '{{F_ALU, 4'd1, 10'h011}, {F_ALU, 4'd2, 10'h022}, {F_ALU, 4'd3, 10'h033},
                {F_BRA, 4'd7, 10'h044}, {F_BZ, 4'd7, 10'h055}};
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, ins[i], 1'b1, 1'b0);
            cycle();
            checks++;
            if (obs() !== exp[i]) begin
                errors++; $display("FAIL class_bundle[%0d]: got %h want %h", i, obs(), exp[i]);
            end
            drain();
        end
        drive(1'b1, mk(OP_STB, 10'h066), 1'b1, 1'b0);
        cycle();
        checks++;
        if (obs() !== {F_STB, 4'd7, 10'h066}) begin
            errors++; $display("FAIL stb_bundle: got %h want %h", obs(), {F_STB, 4'd7, 10'h066});
        end
        drain();
    endtask

    task automatic test_flush();
        drive(1'b1, mk(OP_STA, 10'h0D0), 1'b1, 1'b0);
        cycle();
        drive(1'b1, mk(OP_LDB, 10'h0D1), 1'b0, 1'b1);
        checks++;
        if (oReady !== 1'b0) begin
            errors++; $display("FAIL flush_ready: got %b want 0", oReady);
        end
        cycle();
        checks++;
        if (obs() !== RST_OBS) begin
            errors++; $display("FAIL flush_kill: got %h want %h", obs(), RST_OBS);
        end
        drive(1'b1, mk(OP_LDB, 10'h0D1), 1'b1, 1'b0);
        checks++;
        if (oReady !== 1'b1) begin
            errors++; $display("FAIL after_flush_ready: got %b want 1", oReady);
        end
        cycle();
        checks++;
        if (obs() !== {F_LDB, 4'd7, 10'h0D1}) begin
            errors++; $display("FAIL after_flush_bundle: got %h want %h", obs(), {F_LDB, 4'd7, 10'h0D1});
        end
        drain();
    endtask

    task automatic test_async_reset();
        drive(1'b1, mk(OP_LDA, 10'h0E0), 1'b1, 1'b0);
        cycle();
        drive(1'b1, mk(OP_LDB, 10'h0E1), 1'b1, 1'b0);
        cycle();
        drive(1'b1, mk(OP_STA, 10'h0E2), 1'b1, 1'b0);
        checks++;
        if (oReady !== 1'b0) begin
            errors++; $display("FAIL midstall_ready: got %b want 0", oReady);
        end
        #2 Reset = 1'b0;
        #1;
        checks++;
        if (obs() !== RST_OBS) begin
            errors++; $display("FAIL async_reset_outputs: got %h want %h", obs(), RST_OBS);
        end
        #1 Reset = 1'b1;
        #1;
        checks++;
        if (oReady !== 1'b1) begin
            errors++; $display("FAIL post_reset_ready: got %b want 1", oReady);
        end
        cycle();
        checks++;
        if (obs() !== {F_STA, 4'd7, 10'h0E2}) begin
            errors++; $display("FAIL post_reset_sta: got %h want %h", obs(), {F_STA, 4'd7, 10'h0E2});
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_raw_stall();
        test_backpressure();
        test_classes();
        test_flush();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

endmodule
